// File: rtl/csr_trap_ctrl_if.sv
// csr_trap_ctrl_if: EX-stage, pipeline-control and CSR-file port bundle for csr_trap_ctrl
interface csr_trap_ctrl_if;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        csr_op;
  logic [2:0]  csr_funct3;
  logic [11:0] csr_addr;
  logic [4:0]  csr_src;
  logic [31:0] csr_rs1_data;
  logic        ecall;
  logic        ebreak;
  logic        mret;
  logic        ext_irq;
  logic [31:0] csr_rd_data;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        CSR_write_en;
  logic [11:0] CSR_write_addr;
  logic [31:0] CSR_data_write;
  logic [11:0] CSR_read_addr;
  logic [31:0] CSR_data_read;
  modport master (
    output ex_valid, ex_pc, csr_op, csr_funct3, csr_addr, csr_src, csr_rs1_data,
    output ecall, ebreak, mret, ext_irq, CSR_data_read,
    input  csr_rd_data, stall, flush, redirect, redirect_pc,
    input  CSR_write_en, CSR_write_addr, CSR_data_write, CSR_read_addr
  );
  modport slave (
    input  ex_valid, ex_pc, csr_op, csr_funct3, csr_addr, csr_src, csr_rs1_data,
    input  ecall, ebreak, mret, ext_irq, CSR_data_read,
    output csr_rd_data, stall, flush, redirect, redirect_pc,
    output CSR_write_en, CSR_write_addr, CSR_data_write, CSR_read_addr
  );
endinterface

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: Zicsr read-modify-write execution and machine-mode trap/mret sequencing
module csr_trap_ctrl #(
  parameter logic [11:0] ADDR_MSTATUS = 12'h300,
  parameter logic [11:0] ADDR_MTVEC   = 12'h305,
  parameter logic [11:0] ADDR_MEPC    = 12'h341,
  parameter logic [11:0] ADDR_MCAUSE  = 12'h342
) (
  input logic          clk,
  input logic          rst,
  csr_trap_ctrl_if.slave bus
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] T_CAUSE  = 3'd1;
  localparam logic [2:0] T_STATUS = 3'd2;
  localparam logic [2:0] T_VEC    = 3'd3;
  localparam logic [2:0] M_EPC    = 3'd4;
  logic [2:0]  state, state_nx;
  logic [31:0] cause, cause_nx;
  logic        mie;
  logic        ev_irq, ev_trap, ev_mret, ev_csr, op_ok, op_we;
  logic [31:0] old, src, csr_new;
  // The single read port is needed for csr_addr in the same cycle the interrupt
  // is qualified, so MIE is tracked from this block's own mstatus writes.
  assign ev_irq  = bus.ex_valid & bus.ext_irq & mie;
  assign ev_trap = ev_irq | (bus.ex_valid & (bus.ecall | bus.ebreak));
  assign ev_mret = bus.ex_valid & bus.mret & ~ev_trap;
  assign ev_csr  = bus.ex_valid & bus.csr_op & ~ev_trap & ~bus.mret;
  assign old     = bus.CSR_data_read;
  assign src     = bus.csr_funct3[2] ? {27'b0, bus.csr_src} : bus.csr_rs1_data;
  assign op_ok   = |bus.csr_funct3[1:0];
  assign op_we   = (bus.csr_funct3[1:0] == 2'b01) | (|bus.csr_src);
  assign csr_new = bus.csr_funct3[1:0] == 2'b01 ? src : bus.csr_funct3[0] ? old & ~src : old | src;
  // Next state and all outputs; every output is held at zero while rst is high
  always_comb begin
    state_nx           = state;
    cause_nx           = cause;
    bus.csr_rd_data    = '0;
    bus.stall          = 1'b0;
    bus.flush          = 1'b0;
    bus.redirect       = 1'b0;
    bus.redirect_pc    = '0;
    bus.CSR_write_en   = 1'b0;
    bus.CSR_write_addr = '0;
    bus.CSR_data_write = '0;
    bus.CSR_read_addr  = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (ev_trap) begin
            bus.CSR_write_en   = 1'b1;
            bus.CSR_write_addr = ADDR_MEPC;
            bus.CSR_data_write = {bus.ex_pc[31:2], 2'b00};
            bus.stall          = 1'b1;
            bus.flush          = 1'b1;
            cause_nx           = ev_irq ? 32'h8000000B : bus.ecall ? 32'd11 : 32'd3;
            state_nx           = T_CAUSE;
          end else if (ev_mret) begin
            bus.CSR_read_addr  = ADDR_MSTATUS;
            bus.CSR_write_en   = 1'b1;
            bus.CSR_write_addr = ADDR_MSTATUS;
            bus.CSR_data_write = {old[31:8], 1'b1, old[6:4], old[7], old[2:0]};
            bus.stall          = 1'b1;
            bus.flush          = 1'b1;
            state_nx           = M_EPC;
          end else if (ev_csr && op_ok) begin
            bus.CSR_read_addr  = bus.csr_addr;
            bus.csr_rd_data    = old;
            bus.CSR_write_en   = op_we;
            bus.CSR_write_addr = bus.csr_addr;
            bus.CSR_data_write = csr_new;
          end
        end
        T_CAUSE: begin
          bus.CSR_write_en   = 1'b1;
          bus.CSR_write_addr = ADDR_MCAUSE;
          bus.CSR_data_write = cause;
          bus.stall          = 1'b1;
          state_nx           = T_STATUS;
        end
        T_STATUS: begin
          bus.CSR_read_addr  = ADDR_MSTATUS;
          bus.CSR_write_en   = 1'b1;
          bus.CSR_write_addr = ADDR_MSTATUS;
          bus.CSR_data_write = {old[31:8], old[3], old[6:4], 1'b0, old[2:0]};
          bus.stall          = 1'b1;
          state_nx           = T_VEC;
        end
        T_VEC: begin
          bus.CSR_read_addr = ADDR_MTVEC;
          bus.redirect      = 1'b1;
          bus.redirect_pc   = old & ~32'h3;
          state_nx          = IDLE;
        end
        M_EPC: begin
          bus.CSR_read_addr = ADDR_MEPC;
          bus.redirect      = 1'b1;
          bus.redirect_pc   = old & ~32'h3;
          state_nx          = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end
  // State, latched trap cause and the mstatus.MIE shadow
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cause <= '0;
      mie   <= 1'b0;
    end else begin
      state <= state_nx;
      cause <= cause_nx;
      if (bus.CSR_write_en && bus.CSR_write_addr == ADDR_MSTATUS) mie <= bus.CSR_data_write[3];
    end
  end
endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb_csr_trap_ctrl: randomized self-checking bench with a CSR-file model and spec-level reference
module tb_csr_trap_ctrl;
  localparam logic [11:0] MST = 12'h300;
  localparam logic [11:0] MTV = 12'h305;
  localparam logic [11:0] MEPC = 12'h341;
  localparam logic [11:0] MCA = 12'h342;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [31:0] file [0:4095] = '{default: 32'h0};
  logic [31:0] mdl [0:4095] = '{default: 32'h0};
  logic [11:0] addrs [6] = '{12'h340, 12'h341, 12'h342, 12'h305, 12'h300, 12'h7C0};
  always #5 clk = ~clk;
  csr_trap_ctrl_if bus();
  csr_trap_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));
  assign bus.CSR_data_read = file[bus.CSR_read_addr];
  always @(posedge clk) if (bus.CSR_write_en) file[bus.CSR_write_addr] <= bus.CSR_data_write;

  task automatic drive(input logic v, input logic [31:0] pc, input logic op, input logic [2:0] f3,
                       input logic [11:0] a, input logic [4:0] s, input logic [31:0] r,
                       input logic ec, input logic eb, input logic mr, input logic irq);
    @(negedge clk);
    bus.ex_valid = v; bus.ex_pc = pc; bus.csr_op = op; bus.csr_funct3 = f3; bus.csr_addr = a;
    bus.csr_src = s; bus.csr_rs1_data = r; bus.ecall = ec; bus.ebreak = eb; bus.mret = mr; bus.ext_irq = irq;
    #1;
  endtask

  task automatic junk();
    drive(1'($urandom), $urandom, 1'($urandom), 3'($urandom), 12'($urandom), 5'($urandom), $urandom,
          1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic quiet();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_quiet();
    checks++;
    if ({bus.stall, bus.flush, bus.redirect, bus.CSR_write_en, bus.csr_rd_data} !== '0) begin
      failures++;
      $display("FAIL quiet: got stall/flush/redir/we=%b%b%b%b rd=%h want all 0", bus.stall, bus.flush, bus.redirect, bus.CSR_write_en, bus.csr_rd_data);
    end
  endtask

  task automatic chk_csr();
    logic [31:0] old, sv, nv;
    logic valid, we;
    old = mdl[bus.csr_addr];
    valid = bus.csr_funct3[1:0] != 2'b00;
    sv = bus.csr_funct3[2] ? {27'b0, bus.csr_src} : bus.csr_rs1_data;
    case (bus.csr_funct3[1:0])
      2'b01: nv = sv;
      2'b10: nv = old | sv;
      2'b11: nv = old & ~sv;
      default: nv = old;
    endcase
    we = valid && (bus.csr_funct3[1:0] == 2'b01 || bus.csr_src != 0);
    checks++;
    if (bus.csr_rd_data !== (valid ? old : 32'h0)) begin
      failures++; $display("FAIL csr_rd: got %h want %h", bus.csr_rd_data, valid ? old : 32'h0);
    end
    checks++;
    if ({bus.stall, bus.flush, bus.redirect, bus.CSR_write_en} !== {3'b000, we}) begin
      failures++; $display("FAIL csr_ctl: got %b want %b", {bus.stall, bus.flush, bus.redirect, bus.CSR_write_en}, {3'b000, we});
    end
    if (we) begin
      checks++;
      if ({bus.CSR_write_addr, bus.CSR_data_write} !== {bus.csr_addr, nv}) begin
        failures++; $display("FAIL csr_wr: got %h/%h want %h/%h", bus.CSR_write_addr, bus.CSR_data_write, bus.csr_addr, nv);
      end
      mdl[bus.csr_addr] = nv;
    end
  endtask

  task automatic chk_trap(input logic [31:0] cause, input logic [31:0] pc);
    logic [31:0] ns;
    checks++;
    if ({bus.stall, bus.flush, bus.redirect, bus.CSR_write_en, |bus.csr_rd_data} !== 5'b11010) begin
      failures++; $display("FAIL trap_e_ctl: got %b want 11010", {bus.stall, bus.flush, bus.redirect, bus.CSR_write_en, |bus.csr_rd_data});
    end
    checks++;
    if ({bus.CSR_write_addr, bus.CSR_data_write} !== {MEPC, pc & ~32'h3}) begin
      failures++; $display("FAIL trap_mepc: got %h/%h want %h/%h", bus.CSR_write_addr, bus.CSR_data_write, MEPC, pc & ~32'h3);
    end
    mdl[MEPC] = pc & ~32'h3;
    junk();
    checks++;
    if ({bus.stall, bus.flush, bus.redirect, bus.CSR_write_en, bus.CSR_write_addr, bus.CSR_data_write} !== {4'b1001, MCA, cause}) begin
      failures++; $display("FAIL trap_cause: got %b %h/%h want 1001 %h/%h", {bus.stall, bus.flush, bus.redirect, bus.CSR_write_en}, bus.CSR_write_addr, bus.CSR_data_write, MCA, cause);
    end
    mdl[MCA] = cause;
    junk();
    ns = mdl[MST];
    ns[7] = mdl[MST][3];
    ns[3] = 1'b0;
    checks++;
    if ({bus.stall, bus.flush, bus.redirect, bus.CSR_write_en, bus.CSR_write_addr, bus.CSR_data_write} !== {4'b1001, MST, ns}) begin
      failures++; $display("FAIL trap_status: got %b %h/%h want 1001 %h/%h", {bus.stall, bus.flush, bus.redirect, bus.CSR_write_en}, bus.CSR_write_addr, bus.CSR_data_write, MST, ns);
    end
    mdl[MST] = ns;
    junk();
    checks++;
    if ({bus.stall, bus.flush, bus.redirect, bus.CSR_write_en, bus.redirect_pc} !== {4'b0010, mdl[MTV] & ~32'h3}) begin
      failures++; $display("FAIL trap_vec: got %b pc=%h want 0010 pc=%h", {bus.stall, bus.flush, bus.redirect, bus.CSR_write_en}, bus.redirect_pc, mdl[MTV] & ~32'h3);
    end
  endtask

  task automatic chk_mret();
    logic [31:0] ns;
    ns = mdl[MST];
    ns[3] = mdl[MST][7];
    ns[7] = 1'b1;
    checks++;
    if ({bus.stall, bus.flush, bus.redirect, bus.CSR_write_en, bus.CSR_write_addr, bus.CSR_data_write} !== {4'b1101, MST, ns}) begin
      failures++; $display("FAIL mret_status: got %b %h/%h want 1101 %h/%h", {bus.stall, bus.flush, bus.redirect, bus.CSR_write_en}, bus.CSR_write_addr, bus.CSR_data_write, MST, ns);
    end
    mdl[MST] = ns;
    junk();
    checks++;
    if ({bus.stall, bus.flush, bus.redirect, bus.CSR_write_en, bus.redirect_pc} !== {4'b0010, mdl[MEPC] & ~32'h3}) begin
      failures++; $display("FAIL mret_redir: got %b pc=%h want 0010 pc=%h", {bus.stall, bus.flush, bus.redirect, bus.CSR_write_en}, bus.redirect_pc, mdl[MEPC] & ~32'h3);
    end
  endtask

  task automatic expect_event();
    logic irq_t;
    irq_t = bus.ex_valid & bus.ext_irq & mdl[MST][3];
    if (irq_t || (bus.ex_valid && (bus.ecall || bus.ebreak)))
      chk_trap(irq_t ? 32'h8000000B : bus.ecall ? 32'd11 : 32'd3, bus.ex_pc);
    else if (bus.ex_valid && bus.mret) chk_mret();
    else if (bus.ex_valid && bus.csr_op) chk_csr();
    else chk_quiet();
  endtask

  task automatic csr(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] s, input logic [31:0] r);
    drive(1, 32'h1000, 1, f3, a, s, r, 0, 0, 0, 0);
    chk_csr();
  endtask

  task automatic chk_file(input string name, input logic [11:0] a, input logic [31:0] want);
    checks++;
    if (file[a] !== want) begin
      failures++; $display("FAIL %s: csr[%h] got %h want %h", name, a, file[a], want);
    end
  endtask

  task automatic chk_all_zero(input string name);
    checks++;
    if ({bus.csr_rd_data, bus.stall, bus.flush, bus.redirect, bus.redirect_pc, bus.CSR_write_en,
         bus.CSR_write_addr, bus.CSR_data_write, bus.CSR_read_addr} !== '0) begin
      failures++; $display("FAIL %s: outputs not zero stall=%b we=%b redir=%b rd=%h", name, bus.stall, bus.CSR_write_en, bus.redirect, bus.csr_rd_data);
    end
  endtask

  task automatic test_reset();
    drive(1, 32'h40, 1, 3'b001, 12'h340, 5'd1, 32'h5, 1, 0, 0, 1);
    chk_all_zero("reset_outputs");
    quiet();
    rst = 1'b0;
    quiet();
    chk_quiet();
  endtask

  task automatic test_csr_ops();
    csr(3'b001, 12'h340, 5'd1, 32'hF0);
    csr(3'b010, 12'h340, 5'd5, 32'h0F);
    checks++;
    if (bus.csr_rd_data !== 32'hF0) begin failures++; $display("FAIL csrrs_rd: got %h want f0", bus.csr_rd_data); end
    csr(3'b010, 12'h340, 5'd0, 32'hFFFF);
    checks++;
    if (bus.csr_rd_data !== 32'hFF) begin failures++; $display("FAIL csrrs_read: got %h want ff", bus.csr_rd_data); end
    csr(3'b011, 12'h340, 5'd0, 32'hFFFF);
    checks++;
    if ({bus.CSR_write_en, bus.csr_rd_data} !== {1'b0, 32'hFF}) begin failures++; $display("FAIL csrrc_x0: got we=%b rd=%h want we=0 rd=ff", bus.CSR_write_en, bus.csr_rd_data); end
    csr(3'b101, 12'h340, 5'd3, 32'hFFFF);
    csr(3'b000, 12'h340, 5'd7, 32'h1);
    csr(3'b100, 12'h340, 5'd7, 32'h1);
    quiet();
    chk_file("csrrwi", 12'h340, 32'h3);
  endtask

  task automatic test_trap_ecall();
    csr(3'b001, MTV, 5'd1, 32'h100);
    csr(3'b001, MST, 5'd1, 32'h8);
    drive(1, 32'h40, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    expect_event();
    chk_file("ecall_mepc", MEPC, 32'h40);
    chk_file("ecall_mcause", MCA, 32'd11);
    chk_file("ecall_mstatus", MST, 32'h80);
  endtask

  task automatic test_mret();
    csr(3'b001, MEPC, 5'd1, 32'h44);
    drive(1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    expect_event();
    chk_file("mret_mstatus", MST, 32'h88);
    quiet();
    chk_quiet();
  endtask

  task automatic test_irq();
    csr(3'b001, MST, 5'd1, 32'h0);
    drive(1, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    expect_event();
    csr(3'b001, MST, 5'd1, 32'h8);
    drive(1, 32'h304, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    expect_event();
    chk_file("irq_mcause", MCA, 32'h8000000B);
  endtask

  task automatic test_coincident();
    csr(3'b001, MST, 5'd1, 32'h8);
    csr(3'b001, 12'h340, 5'd1, 32'h1234);
    drive(1, 32'h500, 1, 3'b001, 12'h340, 5'd1, 32'hDEAD, 1, 0, 0, 1);
    expect_event();
    chk_file("coinc_mcause", MCA, 32'h8000000B);
    chk_file("coinc_noop", 12'h340, 32'h1234);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      int k;
      k = $urandom_range(0, 19);
      drive($urandom_range(0, 9) != 0, $urandom, k >= 4 || $urandom_range(0, 3) == 0, 3'($urandom),
            addrs[$urandom_range(0, 5)], 5'($urandom_range(0, 3) == 0 ? 0 : $urandom), $urandom,
            k == 0, k == 1, k == 2, k == 3 || $urandom_range(0, 7) == 0);
      expect_event();
    end
    quiet();
    for (int j = 0; j < 6; j++) chk_file("rand_state", addrs[j], mdl[addrs[j]]);
  endtask

  task automatic test_reset_mid();
    csr(3'b001, MST, 5'd1, 32'h8);
    drive(1, 32'h80, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    quiet();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all_zero("reset_t_status");
    quiet();
    rst = 1'b0;
    quiet();
    chk_all_zero("after_reset");
    chk_file("reset_no_status", MST, 32'h8);
  endtask

  initial begin
    test_reset();
    test_csr_ops();
    test_trap_ecall();
    test_mret();
    test_irq();
    test_coincident();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/csr_trap_ctrl.md
# csr_trap_ctrl

Controller that sits directly upstream of the CSR register file. It owns that file's single write port and its read port. In the EX stage it executes Zicsr instructions as read-modify-write operations. It sequences machine-mode trap entry (ecall, ebreak, external interrupt) and mret as multi-cycle writes to mepc, mcause and mstatus, then redirects the PC to the address in mtvec or mepc.

## Interface
Parameters:
- ADDR_MSTATUS, 12'h300, mstatus address
- ADDR_MTVEC, 12'h305, mtvec address
- ADDR_MEPC, 12'h341, mepc address
- ADDR_MCAUSE, 12'h342, mcause address

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  a real instruction occupies EX this cycle
- ex_pc  in  32  PC of the EX instruction
- csr_op  in  1  EX instruction is a Zicsr op
- csr_funct3  in  3  funct3 of that op: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- csr_addr  in  12  CSR address field
- csr_src  in  5  rs1 index (register forms) or zimm (immediate forms)
- csr_rs1_data  in  32  forwarded rs1 value
- ecall, ebreak, mret  in  1 each  decoded EX instruction
- ext_irq  in  1  level external interrupt request
- csr_rd_data  out  32  old CSR value, written back to rd
- stall  out  1  freeze IF/ID/EX
- flush  out  1  squash the EX instruction
- redirect  out  1  one-cycle PC redirect strobe
- redirect_pc  out  32  redirect target
- CSR_write_en  out  1  CSR file write enable
- CSR_write_addr  out  12  CSR file write address
- CSR_data_write  out  32  CSR file write data
- CSR_read_addr  out  12  CSR file read address
- CSR_data_read  in  32  CSR file combinational read data; writes become visible the cycle after the edge

## Operation
- States: IDLE, T_CAUSE, T_STATUS, T_VEC, M_EPC.
- IDLE event priority:
  - irq: ext_irq & mstatus[3] (MIE) & ex_valid
  - ecall
  - ebreak
  - mret
  - csr_op
- ecall, ebreak, mret and csr_op are qualified by ex_valid.
- Trap event in IDLE:
  - write mepc = {ex_pc[31:2],2'b00}
  - latch cause: irq 32'h8000000B, ecall 32'd11, ebreak 32'd3
  - assert stall and flush; go to T_CAUSE
- T_CAUSE: write mcause = latched cause; stall=1; go to T_STATUS.
- T_STATUS:
  - read mstatus, write it back with bit7 (MPIE) set to the old bit3 and bit3 cleared; other bits unchanged
  - stall=1; go to T_VEC
- T_VEC:
  - read mtvec; redirect=1, redirect_pc = mtvec & ~32'h3
  - stall=0, no write; go to IDLE
- mret in IDLE:
  - read mstatus, write it back with bit3 set to the old bit7 and bit7 set to 1
  - stall=1, flush=1; go to M_EPC
- M_EPC: read mepc; redirect=1, redirect_pc = mepc & ~32'h3; stall=0; go to IDLE.
- csr_op in IDLE, with no higher-priority event:
  - CSR_read_addr = csr_addr; csr_rd_data = CSR_data_read
  - source value s = csr_rs1_data for funct3[2]=0, else {27'b0,csr_src}
  - write data: RW/RWI s; RS/RSI old|s; RC/RCI old&~s
  - write enable: always for RW/RWI; for RS/RC/RSI/RCI only when csr_src != 0
  - write address csr_addr; no stall
  - funct3 000 or 100: no write, csr_rd_data=0.
- csr_rd_data = 0 whenever no csr_op is being executed.

## Timing
- Reset (rst high at an edge):
  - state goes to IDLE
  - while rst is high, every output is forced to 0 (CSR_write_en, stall, flush, redirect, redirect_pc, csr_rd_data, addresses, write data)
- Reset mid-sequence aborts the sequence with no further writes. CSR contents are the file's responsibility.
- Trap latency: event cycle E writes mepc; E+1 writes mcause; E+2 writes mstatus; E+3 asserts redirect. Stall is high in E..E+2.
- mret latency: event cycle E writes mstatus; E+1 asserts redirect. Stall is high in E only.
- A trap or mret coincident with csr_op: the CSR op is dropped entirely (no write, csr_rd_data=0).
- Inputs are ignored in non-IDLE states; ext_irq is sampled only in IDLE.
- redirect is exactly one cycle wide. flush is asserted only in the event cycle.
- A CSR op write at edge N is seen by a read in cycle N+1. No internal bypass is provided.

## Test plan
- mtvec=32'h00000100, mstatus=32'h8, ecall at ex_pc=32'h40 -> writes mepc=0x40, mcause=11, mstatus=0x80 on three consecutive edges; redirect to 0x100 on the fourth cycle; stall high for three cycles.
- After the trap above, mepc=0x44 and mret -> mstatus becomes 0x88 and redirect_pc=0x44 the next cycle.
- CSR ops on addr 0x340 = 0xF0:
  - csrrs with rs1=5 and value 0x0F -> csr_rd_data=0xF0, then 0xFF
  - csrrc with csr_src=0 -> no write, rd=0xFF
  - csrrwi with zimm=3 -> 0x3
- ext_irq=1 with mstatus=0 -> ignored; with mstatus=0x8 -> mcause=32'h8000000B.
- ext_irq with ecall and csr_op all in one cycle -> irq cause recorded and no CSR-op write.
- rst asserted in T_STATUS -> no mstatus write, no redirect, state IDLE, all outputs 0 the next cycle.
